// File: rtl/sic4_instr_encoder_pkg.sv
// Shared SIC-4 instruction field layout, FSM state encoding and opcode constants.
// Imported by the encoder, its field packer and the decoder bench.
package sic4_instr_encoder_pkg;

  localparam int OP_W    = 2;
  localparam int REG_W   = 2;
  localparam int FI_W    = 2;
  localparam int INSTR_W = 8;

  localparam int OP_MSB  = 7;
  localparam int RTD_MSB = 5;
  localparam int RS_MSB  = 3;
  localparam int FI_MSB  = 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_FIN  = 2'd2
  } enc_state_e;

  // Opcode values shared with the decoder.
  localparam logic [OP_W-1:0] OPC_ALU  = 2'b00;
  localparam logic [OP_W-1:0] OPC_IMM  = 2'b01;
  localparam logic [OP_W-1:0] OPC_MEM  = 2'b10;
  localparam logic [OP_W-1:0] OPC_BR   = 2'b11;

endpackage

// File: rtl/sic4_instr_encoder_if.sv
// Host/loader <-> encoder <-> instruction RAM bundle for sic4_instr_encoder.
// The csum signal exists only when SIC4_ENC_CHECKSUM_EN is defined.
interface sic4_instr_encoder_if #(
  parameter int ADDR_W = 4,
  parameter int LEN_W  = 5
);
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [LEN_W-1:0]  len;
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        op;
  logic [1:0]        rtd;
  logic [1:0]        rs;
  logic [1:0]        fun_imm;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              busy;
  logic              done;
`ifdef SIC4_ENC_CHECKSUM_EN
  logic [7:0]        csum;
`endif

  modport master (
    output start, base_addr, len, in_valid, op, rtd, rs, fun_imm,
    input  in_ready, mem_we, mem_addr, mem_wdata, busy, done
`ifdef SIC4_ENC_CHECKSUM_EN
    , input csum
`endif
  );

  modport slave (
    input  start, base_addr, len, in_valid, op, rtd, rs, fun_imm,
    output in_ready, mem_we, mem_addr, mem_wdata, busy, done
`ifdef SIC4_ENC_CHECKSUM_EN
    , output csum
`endif
  );

endinterface

// File: rtl/sic4_field_pack.sv
// Combinational packer: places the four SIC-4 fields into one instruction word.
// Reused by the decoder bench for round-trip checks.
module sic4_field_pack
  import sic4_instr_encoder_pkg::*;
(
  input  logic [OP_W-1:0]    op_i,
  input  logic [REG_W-1:0]   rtd_i,
  input  logic [REG_W-1:0]   rs_i,
  input  logic [FI_W-1:0]    fun_imm_i,
  output logic [INSTR_W-1:0] word_o
);

  always_comb begin
    word_o                    = '0;
    word_o[OP_MSB  -: OP_W]   = op_i;
    word_o[RTD_MSB -: REG_W]  = rtd_i;
    word_o[RS_MSB  -: REG_W]  = rs_i;
    word_o[FI_MSB  -: FI_W]   = fun_imm_i;
  end

endmodule

// File: rtl/sic4_instr_encoder.sv
// SIC-4 instruction encoder: packs field tuples and bursts them into instruction RAM.
// Optional running checksum output enabled by SIC4_ENC_CHECKSUM_EN.
module sic4_instr_encoder
  import sic4_instr_encoder_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int LEN_W  = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sic4_instr_encoder_if.slave  bus
);

  enc_state_e          state_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [LEN_W-1:0]    remain_q;
  logic                mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [INSTR_W-1:0]  mem_wdata_q;
  logic [INSTR_W-1:0]  word_d;
  logic                accept_d;
  logic                last_d;
  logic                restart_d;
`ifdef SIC4_ENC_CHECKSUM_EN
  logic [INSTR_W-1:0]  csum_q;
`endif

  function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
    return a + ADDR_W'(1);
  endfunction

  sic4_field_pack u_pack (
    .op_i      (bus.op),
    .rtd_i     (bus.rtd),
    .rs_i      (bus.rs),
    .fun_imm_i (bus.fun_imm),
    .word_o    (word_d)
  );

  // A start pulse in LOAD takes priority, so the tuple offered in that cycle is refused.
  assign accept_d  = bus.in_valid && (state_q == S_LOAD) && !bus.start;
  assign last_d    = (remain_q == LEN_W'(1));
  assign restart_d = bus.start && (state_q != S_FIN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      remain_q    <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      mem_we_q <= accept_d;
      if (accept_d) begin
        mem_addr_q  <= addr_q;
        mem_wdata_q <= word_d;
        addr_q      <= addr_inc(addr_q);
        remain_q    <= remain_q - LEN_W'(1);
      end
      case (state_q)
        S_IDLE, S_LOAD: begin
          if (restart_d) begin
            addr_q   <= bus.base_addr;
            remain_q <= bus.len;
            state_q  <= (bus.len == '0) ? S_FIN : S_LOAD;
          end else if (accept_d && last_d) begin
            state_q <= S_FIN;
          end
        end
        S_FIN:   state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef SIC4_ENC_CHECKSUM_EN
  // Accumulate at acceptance so the sum already includes the final word at the done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csum_q <= '0;
    end else if (restart_d) begin
      csum_q <= '0;
    end else if (accept_d) begin
      csum_q <= csum_q + word_d;
    end
  end

  assign bus.csum = csum_q;
`endif

  assign bus.in_ready  = (state_q == S_LOAD);
  assign bus.busy      = (state_q == S_LOAD);
  assign bus.done      = (state_q == S_FIN);
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

endmodule
